// File: rtl/embedding_lookup_arbiter_pkg.sv
// Shared types and default sizes for the embedding lookup arbiter.
package embedding_lookup_arbiter_pkg;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_INDEX_WIDTH = 10;
    localparam int DEF_NUM_REQ     = 3;
    // One table row carries eight embedding elements.
    localparam int ROW_WIDTH       = DEF_DATA_WIDTH * 8;
    // Requester ids travel on a 2-bit field (rsp_id), so up to four requesters.
    localparam int ID_WIDTH        = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } lookup_state_t;

endpackage

// File: rtl/embedding_lookup_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first requester after last_grant wins.
module rr_arbiter #(
    parameter int NUM_REQ  = 3,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last_grant,
    output logic [NUM_REQ-1:0]  grant
);

    logic [NUM_REQ-1:0] upper_mask;
    logic [NUM_REQ-1:0] upper_req;
    logic [NUM_REQ-1:0] pick_src;

    // Prefer the lowest requester above last_grant; wrap to the lowest overall.
    always_comb begin
        upper_mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (i > int'(last_grant)) upper_mask[i] = 1'b1;
        end
        upper_req = req & upper_mask;
        pick_src  = (|upper_req) ? upper_req : req;
        grant     = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (pick_src[i]) begin
                grant    = '0;
                grant[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/embedding_lookup_arbiter.sv
// Shares one embedding table between NUM_REQ lookup engines, one lookup at a time.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for a request; req_ready pulses on the granted one
// READ    | table read enable and row index driven for one cycle
// CAPT    | registered table row captured into rsp_data
// RESP    | response held until rsp_ready
module embedding_lookup_arbiter
    import embedding_lookup_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int NUM_REQ     = DEF_NUM_REQ,
    parameter int INDEX_WIDTH = DEF_INDEX_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*INDEX_WIDTH-1:0] req_index,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tbl_read_enable,
    output logic [INDEX_WIDTH-1:0]         tbl_index,
    input  logic [DATA_WIDTH*8-1:0]        tbl_data,
    output logic                           rsp_valid,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [DATA_WIDTH*8-1:0]        rsp_data,
    input  logic                           rsp_ready
);

    lookup_state_t           state;
    logic [ID_WIDTH-1:0]     last_grant;
    logic [ID_WIDTH-1:0]     lat_id;
    logic [ID_WIDTH-1:0]     grant_id;
    logic [NUM_REQ-1:0]      grant;
    logic [INDEX_WIDTH-1:0]  sel_index;

    rr_arbiter #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr (
        .req        (req_valid),
        .last_grant (last_grant),
        .grant      (grant)
    );

    // Encode the one-hot grant and pick out that requester's row index.
    always_comb begin
        grant_id  = '0;
        sel_index = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_id  = ID_WIDTH'(i);
                sel_index = req_index[i*INDEX_WIDTH +: INDEX_WIDTH];
            end
        end
    end

    // Accept is combinational so the handshake completes in the grant cycle,
    // keeping the grant-to-response latency at three cycles.
    assign req_ready = (state == ST_IDLE) ? grant : '0;

    // Lookup sequencer; table and response outputs are registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= ST_IDLE;
            last_grant      <= ID_WIDTH'(NUM_REQ - 1);
            lat_id          <= '0;
            tbl_read_enable <= 1'b0;
            tbl_index       <= '0;
            rsp_valid       <= 1'b0;
            rsp_id          <= '0;
            rsp_data        <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (|grant) begin
                        lat_id          <= grant_id;
                        last_grant      <= grant_id;
                        tbl_read_enable <= 1'b1;
                        tbl_index       <= sel_index;
                        state           <= ST_READ;
                    end
                end
                ST_READ: begin
                    tbl_read_enable <= 1'b0;
                    tbl_index       <= '0;
                    state           <= ST_CAPT;
                end
                ST_CAPT: begin
                    rsp_data  <= tbl_data;
                    rsp_id    <= lat_id;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_embedding_lookup_arbiter.sv
// Bench for embedding_lookup_arbiter: directed scenarios plus random traffic
// against a cycle-timeline reference model.
module tb_embedding_lookup_arbiter;
    import embedding_lookup_arbiter_pkg::*;

    localparam int NR = 3;
    localparam int IW = 10;
    localparam int RW = ROW_WIDTH;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NR-1:0] req_valid = '0;
    logic [NR*IW-1:0] req_index = '0;
    logic [NR-1:0] req_ready;
    logic          tbl_read_enable;
    logic [IW-1:0] tbl_index;
    logic [RW-1:0] tbl_data = '0;
    logic          rsp_valid;
    logic [1:0]    rsp_id;
    logic [RW-1:0] rsp_data;
    logic          rsp_ready = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    int model_last = NR - 1;

    embedding_lookup_arbiter #(
        .DATA_WIDTH  (8),
        .NUM_REQ     (NR),
        .INDEX_WIDTH (IW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_index       (req_index),
        .req_ready       (req_ready),
        .tbl_read_enable (tbl_read_enable),
        .tbl_index       (tbl_index),
        .tbl_data        (tbl_data),
        .rsp_valid       (rsp_valid),
        .rsp_id          (rsp_id),
        .rsp_data        (rsp_data),
        .rsp_ready       (rsp_ready)
    );

    always #5 clk = ~clk;

    // Table contents are a fixed hash of the row index.
    function automatic logic [RW-1:0] row_of(int idx);
        logic [63:0] h;
        h = (64'(idx) + 64'd1) * 64'h9E37_79B9_7F4A_7C15;
        return RW'(h ^ 64'h0123_4567_89AB_CDEF);
    endfunction

    // Table memory: registered read, zero when not enabled.
    always @(posedge clk) tbl_data <= tbl_read_enable ? row_of(int'(tbl_index)) : '0;

    // Round-robin reference: first valid requester after last, wrapping.
    function automatic int rr_pick(logic [NR-1:0] v, int last);
        for (int k = 1; k <= NR; k++) begin
            int c;
            c = (last + k) % NR;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(int g);
        logic [NR-1:0] e;
        e = '0;
        if (g >= 0) e[g] = 1'b1;
        return e;
    endfunction

    task automatic set_index(int r, int v);
        req_index[r*IW +: IW] = IW'(v);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        model_last = NR - 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b0;
        next_cycle();
        next_cycle();
        settle();
        n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_req_ready: got %b want 000", req_ready); end
        n_cmp++; if (tbl_read_enable !== 1'b0) begin n_err++; $display("FAIL reset_tbl_re: got %b want 0", tbl_read_enable); end
        n_cmp++; if (tbl_index !== '0) begin n_err++; $display("FAIL reset_tbl_index: got %0d want 0", tbl_index); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        n_cmp++; if (rsp_data !== '0) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        next_cycle();
        rst_n = 1'b1;
        model_last = NR - 1;
        settle();
        n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL reset_release_ready: got %b want 000", req_ready); end
    endtask

    task automatic test_single();
        next_cycle();
        req_valid = 3'b001; set_index(0, 5); rsp_ready = 1'b1;
        settle();
        n_cmp++; if (req_ready !== 3'b001) begin n_err++; $display("FAIL single_grant: got %b want 001", req_ready); end
        model_last = 0;
        next_cycle();
        req_valid = '0;
        settle();
        n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL single_ready_pulse: got %b want 000", req_ready); end
        n_cmp++; if (tbl_read_enable !== 1'b1) begin n_err++; $display("FAIL single_read_en: got %b want 1", tbl_read_enable); end
        n_cmp++; if (tbl_index !== 10'd5) begin n_err++; $display("FAIL single_tbl_index: got %0d want 5", tbl_index); end
        next_cycle(); settle();
        n_cmp++; if (tbl_read_enable !== 1'b0 || tbl_index !== '0) begin n_err++; $display("FAIL single_read_one_cycle: got en=%b idx=%0d want en=0 idx=0", tbl_read_enable, tbl_index); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_early_rsp: got %b want 0", rsp_valid); end
        next_cycle(); settle();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL single_rsp_id: got %0d want 0", rsp_id); end
        n_cmp++; if (rsp_data !== row_of(5)) begin n_err++; $display("FAIL single_rsp_data: got %h want %h", rsp_data, row_of(5)); end
        next_cycle(); settle();
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_done: got %b want 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        int order [4];
        int idx_q [NR];
        int cur_idx;
        int k;
        logic [NR-1:0] e;
        order = '{0, 1, 2, 0};
        cur_idx = 0;
        apply_reset();
        for (int r = 0; r < NR; r++) idx_q[r] = $urandom_range(0, 1023);
        for (int c = 0; c < 16; c++) begin
            next_cycle();
            req_valid = '1; rsp_ready = 1'b1;
            for (int r = 0; r < NR; r++) set_index(r, idx_q[r]);
            settle();
            k = c / 4;
            case (c % 4)
                0: begin
                    e = onehot(order[k]);
                    n_cmp++; if (req_ready !== e) begin n_err++; $display("FAIL rr_grant_%0d: got %b want %b", k, req_ready, e); end
                    cur_idx = idx_q[order[k]];
                    idx_q[order[k]] = $urandom_range(0, 1023);
                end
                1: begin
                    n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL rr_no_ready_read: got %b want 000", req_ready); end
                    n_cmp++; if (tbl_read_enable !== 1'b1 || tbl_index !== IW'(cur_idx)) begin n_err++; $display("FAIL rr_read_%0d: got en=%b idx=%0d want en=1 idx=%0d", k, tbl_read_enable, tbl_index, cur_idx); end
                end
                2: begin
                    n_cmp++; if (req_ready !== '0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL rr_capt_%0d: got rdy=%b rv=%b want 000/0", k, req_ready, rsp_valid); end
                end
                default: begin
                    n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(order[k])) begin n_err++; $display("FAIL rr_rsp_%0d: got rv=%b id=%0d want 1/%0d", k, rsp_valid, rsp_id, order[k]); end
                    n_cmp++; if (rsp_data !== row_of(cur_idx)) begin n_err++; $display("FAIL rr_data_%0d: got %h want %h", k, rsp_data, row_of(cur_idx)); end
                end
            endcase
        end
        model_last = 0;
    endtask

    task automatic test_backpressure();
        int g, g2, id1, id2;
        logic [NR-1:0] e;
        id1 = $urandom_range(0, 1023);
        id2 = $urandom_range(0, 1023);
        next_cycle();
        req_valid = 3'b010; set_index(1, id1); rsp_ready = 1'b0;
        g = rr_pick(3'b010, model_last);
        e = onehot(g);
        settle();
        n_cmp++; if (req_ready !== e) begin n_err++; $display("FAIL bp_grant: got %b want %b", req_ready, e); end
        model_last = g;
        next_cycle();
        req_valid = 3'b101; set_index(0, $urandom_range(0, 1023)); set_index(2, id2);
        settle();
        n_cmp++; if (tbl_index !== IW'(id1)) begin n_err++; $display("FAIL bp_tbl_index: got %0d want %0d", tbl_index, id1); end
        next_cycle(); settle();
        for (int h = 0; h < 10; h++) begin
            next_cycle(); settle();
            n_cmp++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(g) || rsp_data !== row_of(id1) || req_ready !== '0 || tbl_read_enable !== 1'b0) begin
                n_err++;
                $display("FAIL bp_hold_%0d: got rv=%b id=%0d data=%h rdy=%b re=%b want 1/%0d/%h/000/0", h, rsp_valid, rsp_id, rsp_data, req_ready, tbl_read_enable, g, row_of(id1));
            end
        end
        next_cycle();
        rsp_ready = 1'b1;
        settle();
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_accept: got %b want 1", rsp_valid); end
        next_cycle();
        settle();
        g2 = rr_pick(3'b101, model_last);
        e = onehot(g2);
        n_cmp++; if (req_ready !== e) begin n_err++; $display("FAIL bp_held_request: got %b want %b", req_ready, e); end
        model_last = g2;
        next_cycle();
        req_valid = '0;
        next_cycle(); next_cycle(); settle();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g2) || rsp_data !== row_of(id2)) begin n_err++; $display("FAIL bp_second_rsp: got rv=%b id=%0d want 1/%0d", rsp_valid, rsp_id, g2); end
        next_cycle(); next_cycle();
    endtask

    task automatic test_reset_mid();
        int idx, g;
        logic [NR-1:0] e;
        idx = $urandom_range(0, 1023);
        next_cycle();
        req_valid = 3'b001; set_index(0, idx); rsp_ready = 1'b1;
        g = rr_pick(3'b001, model_last);
        e = onehot(g);
        settle();
        n_cmp++; if (req_ready !== e) begin n_err++; $display("FAIL rmid_grant: got %b want %b", req_ready, e); end
        next_cycle();
        req_valid = '0;
        next_cycle();
        rst_n = 1'b0;
        next_cycle();
        rst_n = 1'b1;
        settle();
        n_cmp++;
        if (req_ready !== '0 || tbl_read_enable !== 1'b0 || tbl_index !== '0 || rsp_valid !== 1'b0 || rsp_id !== 2'd0 || rsp_data !== '0) begin
            n_err++;
            $display("FAIL rmid_outputs: got rdy=%b re=%b idx=%0d rv=%b id=%0d data=%h want all zero", req_ready, tbl_read_enable, tbl_index, rsp_valid, rsp_id, rsp_data);
        end
        model_last = NR - 1;
        for (int h = 0; h < 6; h++) begin
            next_cycle(); settle();
            n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rmid_no_rsp_%0d: got %b want 0", h, rsp_valid); end
        end
    endtask

    task automatic test_max_index();
        int g;
        logic [NR-1:0] e;
        next_cycle();
        req_valid = 3'b100; set_index(2, 1023); rsp_ready = 1'b1;
        g = rr_pick(3'b100, model_last);
        e = onehot(g);
        settle();
        n_cmp++; if (req_ready !== e) begin n_err++; $display("FAIL max_grant: got %b want %b", req_ready, e); end
        model_last = g;
        next_cycle();
        req_valid = '0;
        settle();
        n_cmp++; if (tbl_index !== 10'd1023) begin n_err++; $display("FAIL max_tbl_index: got %0d want 1023", tbl_index); end
        next_cycle(); next_cycle(); settle();
        n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin n_err++; $display("FAIL max_rsp_id: got rv=%b id=%0d want 1/2", rsp_valid, rsp_id); end
        n_cmp++; if (rsp_data !== row_of(1023)) begin n_err++; $display("FAIL max_rsp_data: got %h want %h", rsp_data, row_of(1023)); end
        next_cycle();
    endtask

    task automatic test_drop();
        int g;
        logic [NR-1:0] e;
        next_cycle();
        req_valid = 3'b110; set_index(1, $urandom_range(0, 1023)); set_index(2, $urandom_range(0, 1023));
        rsp_ready = 1'b1;
        g = rr_pick(3'b110, model_last);
        e = onehot(g);
        settle();
        n_cmp++; if (req_ready !== e) begin n_err++; $display("FAIL drop_first_grant: got %b want %b", req_ready, e); end
        model_last = g;
        next_cycle();
        set_index(g, $urandom_range(0, 1023));
        next_cycle(); next_cycle(); next_cycle();
        settle();
        g = rr_pick(3'b110, model_last);
        e = onehot(g);
        n_cmp++; if (req_ready !== e) begin n_err++; $display("FAIL drop_second_grant: got %b want %b", req_ready, e); end
        model_last = g;
        next_cycle();
        req_valid = '0;
        for (int h = 0; h < 5; h++) begin
            if (h > 0) next_cycle();
            settle();
            n_cmp++; if (req_ready !== '0) begin n_err++; $display("FAIL drop_spurious_%0d: got %b want 000", h, req_ready); end
            if (h == 2) begin
                n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(g)) begin n_err++; $display("FAIL drop_rsp_id: got rv=%b id=%0d want 1/%0d", rsp_valid, rsp_id, g); end
            end
        end
        next_cycle();
        req_valid = 3'b001; set_index(0, $urandom_range(0, 1023));
        g = rr_pick(3'b001, model_last);
        e = onehot(g);
        settle();
        n_cmp++; if (req_ready !== e) begin n_err++; $display("FAIL drop_third_grant: got %b want %b", req_ready, e); end
        model_last = g;
        next_cycle();
        req_valid = '0;
        next_cycle(); next_cycle(); next_cycle();
    endtask

    task automatic test_random();
        logic [NR-1:0] pend;
        logic [NR-1:0] e_rdy;
        int pidx [NR];
        int busy, age, e_id, e_idx, g;
        logic e_re, e_rv;
        logic [IW-1:0] e_ti;
        apply_reset();
        pend = '0; busy = 0; age = 0; e_id = 0; e_idx = 0;
        for (int r = 0; r < NR; r++) pidx[r] = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            next_cycle();
            for (int r = 0; r < NR; r++) begin
                if (!pend[r] && $urandom_range(0, 1) == 1) begin
                    pend[r] = 1'b1;
                    pidx[r] = ($urandom_range(0, 7) == 0) ? 1023 : int'($urandom_range(0, 1023));
                end
                set_index(r, pidx[r]);
            end
            req_valid = pend;
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (busy != 0) age++;
            g = (busy == 0) ? rr_pick(pend, model_last) : -1;
            e_rdy = onehot(g);
            e_re = (busy != 0 && age == 1);
            e_ti = e_re ? IW'(e_idx) : '0;
            e_rv = (busy != 0 && age >= 3);
            settle();
            n_cmp++; if (req_ready !== e_rdy) begin n_err++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, req_ready, e_rdy); end
            n_cmp++; if (tbl_read_enable !== e_re || tbl_index !== e_ti) begin n_err++; $display("FAIL rand_table@%0d: got en=%b idx=%0d want en=%b idx=%0d", cyc, tbl_read_enable, tbl_index, e_re, e_ti); end
            n_cmp++; if (rsp_valid !== e_rv) begin n_err++; $display("FAIL rand_rsp_valid@%0d: got %b want %b", cyc, rsp_valid, e_rv); end
            if (e_rv) begin
                n_cmp++; if (rsp_id !== 2'(e_id) || rsp_data !== row_of(e_idx)) begin n_err++; $display("FAIL rand_rsp@%0d: got id=%0d data=%h want id=%0d data=%h", cyc, rsp_id, rsp_data, e_id, row_of(e_idx)); end
            end
            if (e_rv && rsp_ready) begin
                busy = 0;
            end else if (busy == 0 && g >= 0) begin
                busy = 1; age = 0; e_id = g; e_idx = pidx[g];
                pend[g] = 1'b0;
                model_last = g;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_max_index();
        test_drop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

endmodule
